// File: rtl/dm_cache_ctrl_if.sv
// CPU load/store port, main-memory beat port and hit/miss counters of dm_cache_ctrl.
// slave is the cache view; master is the CPU/memory/bench view.
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_req;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_done,
        output cpu_rdata, cpu_ready, mem_write, mem_addr, mem_wdata, mem_req,
               hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_done,
        input  cpu_rdata, cpu_ready, mem_write, mem_addr, mem_wdata, mem_req,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with word-serial
// line writeback/refill to main memory and saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 8
) (
    input logic          clk,
    input logic          rst_n,
    dm_cache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND} state_t;

    state_t r_state, w_next;

    logic [ADDR_W-1:2]                r_req_addr;
    logic [31:0]                      r_req_wdata;
    logic                             r_req_write;
    logic                             r_refill;
    logic [OFF_W-1:0]                 r_w;
    logic [NUM_LINES-1:0]             r_valid, r_dirty;
    logic [NUM_LINES-1:0][TAG_W-1:0]  r_tag;
    logic [31:0]                      r_data [NUM_LINES][LINE_WORDS];

    logic [31:0]       r_rdata, r_mem_wdata;
    logic              r_ready, r_mem_req, r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

    logic [OFF_W-1:0] w_off, w_wnext;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag, w_vtag;
    logic             w_hit, w_last;

    assign w_off   = r_req_addr[OFF_W+1:2];
    assign w_idx   = r_req_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign w_tag   = r_req_addr[ADDR_W-1:IDX_W+OFF_W+2];
    assign w_vtag  = r_tag[w_idx];
    assign w_hit   = r_valid[w_idx] && (w_vtag == w_tag);
    assign w_last  = &r_w;
    assign w_wnext = r_w + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.cpu_req) w_next = COMPARE;
            COMPARE:   if (w_hit)              w_next = RESPOND;
                       else if (r_dirty[w_idx]) w_next = WRITEBACK;
                       else                     w_next = ALLOCATE;
            WRITEBACK: if (bus.mem_done && w_last) w_next = ALLOCATE;
            ALLOCATE:  if (bus.mem_done && w_last) w_next = COMPARE;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_write <= 1'b0;
            r_refill    <= 1'b0;
            r_w         <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_tag       <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.cpu_req) begin
                    r_req_addr  <= bus.cpu_addr[ADDR_W-1:2];
                    r_req_wdata <= bus.cpu_wdata;
                    r_req_write <= bus.cpu_write;
                    r_refill    <= 1'b0;
                end
                COMPARE: if (w_hit) begin
                    if (!r_req_write) r_rdata <= r_data[w_idx][w_off];
                    else              r_dirty[w_idx] <= 1'b1;
                    r_ready <= 1'b1;
                    // The re-compare after a refill was already counted as a miss.
                    if (!r_refill && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + 1'b1;
                end else begin
                    if (!(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
                    r_w       <= '0;
                    r_mem_req <= 1'b1;
                    if (r_dirty[w_idx]) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {w_vtag, w_idx, {OFF_W{1'b0}}, 2'b00};
                        r_mem_wdata <= r_data[w_idx][0];
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                WRITEBACK: if (bus.mem_done) begin
                    if (w_last) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_w            <= '0;
                        r_mem_addr     <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
                    end else begin
                        r_w         <= w_wnext;
                        r_mem_addr  <= {w_vtag, w_idx, w_wnext, 2'b00};
                        r_mem_wdata <= r_data[w_idx][w_wnext];
                    end
                end
                ALLOCATE: if (bus.mem_done) begin
                    if (w_last) begin
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_mem_req      <= 1'b0;
                        r_refill       <= 1'b1;
                        r_w            <= '0;
                    end else begin
                        r_w        <= w_wnext;
                        r_mem_addr <= {w_tag, w_idx, w_wnext, 2'b00};
                    end
                end
                RESPOND: r_ready <= 1'b0;
                default: ;
            endcase
        end
    end

    // Data storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (r_state == COMPARE && w_hit && r_req_write)
            r_data[w_idx][w_off] <= r_req_wdata;
        else if (r_state == ALLOCATE && bus.mem_done)
            r_data[w_idx][r_w] <= bus.mem_rdata;
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ready = r_ready;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: behavioural main memory with programmable
// wait states, beat log, and hand-computed expectations per request.
module tb_dm_cache_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(.ADDR_W(10), .CNT_W(8)) bus();

    dm_cache_ctrl #(.ADDR_W(10), .NUM_LINES(4), .LINE_WORDS(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [31:0] mem [256];
    int          wait_cyc = 0;
    int          cnt = 0;
    logic [9:0]  beat_addr [$];
    logic        beat_wr   [$];
    int          stab_err = 0;
    logic        prev_busy = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic        prev_wr = 1'b0;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: done after wait_cyc low cycles; wait_cyc = 0 holds done high.
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_done = 1'b0;
            cnt = 0;
        end else if (cnt >= wait_cyc) begin
            bus.mem_done  = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
            cnt = 0;
        end else begin
            bus.mem_done = 1'b0;
            cnt++;
        end
    end

    always @(posedge clk) begin
        if (!bus.mem_req && bus.mem_write) stab_err++;
        if (prev_busy && bus.mem_req && (bus.mem_addr != prev_addr || bus.mem_write != prev_wr))
            stab_err++;
        prev_busy = bus.mem_req && !bus.mem_done;
        prev_addr = bus.mem_addr;
        prev_wr   = bus.mem_write;
        if (bus.mem_req && bus.mem_done) begin
            beat_addr.push_back(bus.mem_addr);
            beat_wr.push_back(bus.mem_write);
            if (bus.mem_write) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        end
    end

    task automatic cpu_op(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        beat_addr.delete();
        beat_wr.delete();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_write = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.cpu_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.cpu_ready) chk("cpu_ready timeout", 32'(lat), 32'hFFFF_FFFF);
        rd = bus.cpu_rdata;
    endtask

    task automatic chk_beats(input string tag, input logic [9:0] base, input logic wr, input int first);
        for (int i = 0; i < 4; i++) begin
            chk({tag, " addr"}, 32'(beat_addr[first+i]), 32'(base + 10'(4*i)));
            chk({tag, " write"}, 32'(beat_wr[first+i]), 32'(wr));
        end
    endtask

    logic [31:0] rd;
    int lat;

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_done = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[4] = 32'h00ffaabb; mem[5] = 32'hff00ccdd; mem[6] = 32'h00cc2299; mem[7] = 32'hff00bbaa;
        repeat (3) @(negedge clk);
        chk("rst mem_req", 32'(bus.mem_req), 0);
        chk("rst mem_write", 32'(bus.mem_write), 0);
        chk("rst cpu_ready", 32'(bus.cpu_ready), 0);
        chk("rst cpu_rdata", bus.cpu_rdata, 0);
        chk("rst mem_addr", 32'(bus.mem_addr), 0);
        chk("rst hit_cnt", 32'(bus.hit_cnt), 0);
        chk("rst miss_cnt", 32'(bus.miss_cnt), 0);
        rst_n = 1'b1;

        // Cold miss on line 1
        cpu_op(1'b0, 10'h010, 0, rd, lat);
        chk("miss0 beats", 32'(beat_addr.size()), 4);
        chk_beats("miss0", 10'h010, 1'b0, 0);
        chk("miss0 rdata", rd, 32'h00ffaabb);
        chk("miss0 lat", 32'(lat), 7);
        chk("miss0 miss_cnt", 32'(bus.miss_cnt), 1);
        chk("miss0 hit_cnt", 32'(bus.hit_cnt), 0);

        cpu_op(1'b0, 10'h018, 0, rd, lat);
        chk("hit0 beats", 32'(beat_addr.size()), 0);
        chk("hit0 lat", 32'(lat), 2);
        chk("hit0 rdata", rd, 32'h00cc2299);
        chk("hit0 hit_cnt", 32'(bus.hit_cnt), 1);

        cpu_op(1'b1, 10'h014, 32'h12345678, rd, lat);
        chk("st lat", 32'(lat), 2);
        cpu_op(1'b0, 10'h014, 0, rd, lat);
        chk("ld after st rdata", rd, 32'h12345678);
        chk("st hit_cnt", 32'(bus.hit_cnt), 3);
        chk("mem5 untouched", mem[5], 32'hff00ccdd);

        // Dirty conflict miss: writeback then refill
        cpu_op(1'b0, 10'h050, 0, rd, lat);
        chk("wb beats", 32'(beat_addr.size()), 8);
        chk_beats("wb", 10'h010, 1'b1, 0);
        chk_beats("rf", 10'h050, 1'b0, 4);
        chk("wb mem5", mem[5], 32'h12345678);
        chk("wb rdata", rd, 32'hA500_0014);
        chk("wb lat", 32'(lat), 11);
        chk("wb miss_cnt", 32'(bus.miss_cnt), 2);

        // Slow memory: 5 idle cycles per beat on a clean miss
        wait_cyc = 5;
        stab_err = 0;
        cpu_op(1'b0, 10'h098, 0, rd, lat);
        chk("slow beats", 32'(beat_addr.size()), 4);
        chk_beats("slow", 10'h090, 1'b0, 0);
        chk("slow stability", 32'(stab_err), 0);
        chk("slow lat", 32'(lat), 27);
        chk("slow rdata", rd, 32'hA500_0026);
        chk("slow hit_cnt", 32'(bus.hit_cnt), 3);
        chk("slow miss_cnt", 32'(bus.miss_cnt), 3);

        // Dirty line 1 again, then reset during the second writeback beat
        wait_cyc = 0;
        cpu_op(1'b1, 10'h094, 32'hDEADBEEF, rd, lat);
        chk("st2 hit_cnt", 32'(bus.hit_cnt), 4);
        wait_cyc = 3;
        beat_addr.delete();
        beat_wr.delete();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 10'h050;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 100 && beat_addr.size() < 1; i++) @(negedge clk);
        chk("pre-rst beat1", 32'(beat_addr.size()), 1);
        chk("pre-rst mem_req", 32'(bus.mem_req), 1);
        chk("pre-rst mem_write", 32'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("async mem_req", 32'(bus.mem_req), 0);
        chk("async mem_write", 32'(bus.mem_write), 0);
        chk("async hit_cnt", 32'(bus.hit_cnt), 0);
        chk("async miss_cnt", 32'(bus.miss_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc = 0;
        cpu_op(1'b0, 10'h010, 0, rd, lat);
        chk("post-rst beats", 32'(beat_addr.size()), 4);
        chk_beats("post-rst", 10'h010, 1'b0, 0);
        chk("post-rst rdata", rd, 32'h00ffaabb);
        chk("post-rst lat", 32'(lat), 7);
        chk("post-rst miss_cnt", 32'(bus.miss_cnt), 1);
        chk("post-rst hit_cnt", 32'(bus.hit_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
